// File: rtl/top_level.sv
// Hamming SECDED decoder engine: on reset it decodes 15 encoded words held in its own byte memory
// and writes the corrected data words back to the destination region.

module data_mem #(
    parameter int unsigned Depth = 256
) (
    input  logic       clk_i,
    input  logic       we_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o
);

    logic [7:0] core [0:Depth-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            core[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = core[addr_i];

endmodule

module top_level #(
    parameter int unsigned NUM_MSG   = 15,
    parameter int unsigned SRC_BASE  = 30,
    parameter int unsigned DST_BASE  = 0,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    typedef enum logic [2:0] {StIdle, StRdLo, StRdHi, StWrLo, StWrHi, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        done_q, done_d;

    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [15:0] word;
    logic [3:0]  syn;
    logic        par;
    logic [10:0] data_fix;
    logic [1:0]  flag;
    logic [15:0] decoded;

    // Hamming position of data bit j (d1 sits at 3, d2..d4 at 5..7, d5..d11 at 9..15).
    function automatic int unsigned data_pos(input int unsigned j);
        if (j == 0) return 3;
        else if (j < 4) return j + 4;
        else return j + 5;
    endfunction

    assign word = {hi_q, lo_q};

    always_comb begin
        syn = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (word[i]) syn = syn ^ 4'(i);
        end
        par = ^word;
        for (int j = 0; j < 11; j++) begin
            data_fix[j] = word[data_pos(j)] ^ (par && (syn == 4'(data_pos(j))));
        end
        if (par)              flag = 2'b01;
        else if (syn != 4'd0) flag = 2'b10;
        else                  flag = 2'b00;
        decoded = {flag, 3'b000, data_fix};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        done_d    = done_q;
        mem_we    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = decoded[7:0];
        unique case (state_q)
            StIdle: ;
            StRdLo: begin
                mem_addr = 8'(SRC_BASE) + {3'b000, cnt_q, 1'b0};
                lo_d     = mem_rdata;
                state_d  = StRdHi;
            end
            StRdHi: begin
                mem_addr = 8'(SRC_BASE) + {3'b000, cnt_q, 1'b1};
                hi_d     = mem_rdata;
                state_d  = StWrLo;
            end
            StWrLo: begin
                mem_addr  = 8'(DST_BASE) + {3'b000, cnt_q, 1'b0};
                mem_we    = 1'b1;
                mem_wdata = decoded[7:0];
                state_d   = StWrHi;
            end
            StWrHi: begin
                mem_addr  = 8'(DST_BASE) + {3'b000, cnt_q, 1'b1};
                mem_we    = 1'b1;
                mem_wdata = decoded[15:8];
                if (cnt_q == 4'(NUM_MSG - 1)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = StRdLo;
                end
            end
            StDone: done_d = 1'b1;
            default: state_d = StIdle;
        endcase
        // Reset is the start pulse; it must also suppress any write in flight.
        if (reset) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRdLo;
            cnt_q   <= 4'd0;
            lo_q    <= 8'd0;
            hi_q    <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

    data_mem #(
        .Depth (MEM_DEPTH)
    ) dm1 (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: directed and randomized SECDED words, uninterrupted and reset-interrupted runs.

module tb_top_level;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic done;

    top_level dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    always #5 clk = ~clk;

    logic [15:0] src_words [15];
    logic [15:0] exp_words [15];
    logic [7:0]  shadow [256];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int data_pos(input int j);
        if (j == 0) return 3;
        else if (j < 4) return j + 4;
        else return j + 5;
    endfunction

    // Textbook encoder: scatter data, then each parity bit covers positions sharing its index bit.
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        logic        p;
        w = '0;
        for (int j = 0; j < 11; j++) w[data_pos(j)] = d[j];
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++) begin
                if (((pos >> k) & 1) == 1) p = p ^ w[pos];
            end
            w[1 << k] = p;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] w);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = w[data_pos(j)];
        return d;
    endfunction

    task automatic build_stimulus();
        logic [15:0] dir_in [5];
        logic [15:0] dir_out [5];
        dir_in  = '{16'h000F, 16'h002F, 16'h000E, 16'h006F, 16'h0000};
        dir_out = '{16'h0001, 16'h4001, 16'h4001, 16'h8007, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            src_words[i] = dir_in[i];
            exp_words[i] = dir_out[i];
        end
        for (int i = 5; i < 15; i++) begin
            logic [10:0] d;
            logic [15:0] w;
            int nf, p1, p2;
            d  = 11'($urandom);
            nf = i % 3;
            p1 = $urandom_range(0, 15);
            p2 = (p1 + $urandom_range(1, 15)) % 16;
            w  = encode(d);
            if (nf >= 1) w[p1] = ~w[p1];
            if (nf == 2) w[p2] = ~w[p2];
            src_words[i] = w;
            case (nf)
                0:       exp_words[i] = {5'b00000, d};
                1:       exp_words[i] = {5'b01000, d};
                default: exp_words[i] = {5'b10000, extract(w)};
            endcase
        end
    endtask

    task automatic preload();
        for (int a = 0; a < 256; a++) shadow[a] = 8'($urandom);
        for (int i = 0; i < 15; i++) begin
            shadow[30 + 2 * i]     = src_words[i][7:0];
            shadow[30 + 2 * i + 1] = src_words[i][15:8];
        end
        for (int a = 0; a < 256; a++) dut.dm1.core[a] = shadow[a];
    endtask

    // Counts 60 edges after reset release; done must be low at 59 and high at 60.
    task automatic run_to_done(input string tag, input bit abort_at_20);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq({tag, "_done_in_reset"}, 32'(done), 32'd0);
        reset = 1'b0;
        if (abort_at_20) begin
            repeat (20) @(negedge clk);
            check_eq({tag, "_done_before_abort"}, 32'(done), 32'd0);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 30) check_eq({tag, "_done_mid"}, 32'(done), 32'd0);
            if (k == 59) check_eq({tag, "_done_at_59"}, 32'(done), 32'd0);
            if (k == 60) check_eq({tag, "_done_at_60"}, 32'(done), 32'd1);
        end
    endtask

    task automatic check_results(input string tag);
        int bad;
        for (int i = 0; i < 15; i++) begin
            logic [15:0] got;
            got = {dut.dm1.core[2 * i + 1], dut.dm1.core[2 * i]};
            check_eq($sformatf("%s_word%0d", tag, i), 32'(got), 32'(exp_words[i]));
        end
        bad = 0;
        for (int a = 30; a < 60; a++) if (dut.dm1.core[a] !== shadow[a]) bad++;
        check_eq({tag, "_src_untouched"}, 32'(bad), 32'd0);
        bad = 0;
        for (int a = 60; a < 256; a++) if (dut.dm1.core[a] !== shadow[a]) bad++;
        check_eq({tag, "_high_untouched"}, 32'(bad), 32'd0);
    endtask

    initial begin
        build_stimulus();
        preload();
        repeat (2) @(negedge clk);

        run_to_done("run1", 1'b0);
        check_results("run1");
        repeat (5) @(negedge clk);
        check_eq("run1_done_held", 32'(done), 32'd1);

        // Poison the destination so the interrupted run must rewrite every word.
        for (int a = 0; a < 30; a++) dut.dm1.core[a] = 8'hA5;
        run_to_done("run2", 1'b1);
        check_results("run2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
